pulse_extender: RTL and testbench

PULSE_EXTENDER -- requirements
Module: pulse_extender

---
 rtl/pulse_extender_if.sv | 19 +
 rtl/pulse_extender.sv | 77 +++++++
 tb/tb_pulse_extender.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_extender_if.sv
// pulse_extender_if -- signal bundle for the pulse extender.
//   in     : per-channel pulse request (N bits), driven by master
//   len    : extra stretch cycles after a trigger (LW bits), driven by master
//   retrig : 1 = a trigger reloads a running counter, driven by master
//   out    : per-channel stretched pulse (N bits), driven by slave
//   busy   : OR of all out bits, driven by slave
interface pulse_extender_if #(
    parameter int N  = 4,
    parameter int LW = 4
);
    logic [N-1:0]  in;
    logic [LW-1:0] len;
    logic          retrig;
    logic [N-1:0]  out;
    logic          busy;

    modport master (output in, len, retrig, input  out, busy);
    modport slave  (input  in, len, retrig, output out, busy);
endinterface

// File: rtl/pulse_extender.sv
// pulse_extender -- N independent pulse stretchers sharing one length input.
// Each channel runs an LW-bit down-counter; out[i] = trig[i] | (cnt[i] != 0),
// so an isolated trigger gives len+1 cycles of out with zero input latency.
//
// Ports:
//   clk    : clock, all state changes on rising edge
//   nreset : asynchronous active-low reset, clears all counters
//   bus    : pulse_extender_if.slave (in, len, retrig -> out, busy)
//
// Build option: define PULSE_EXTENDER_EDGE_EN to trigger on rising edges of
// in (one len+1 window per edge) instead of on its level.

module pulse_extender_lane #(
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in_bit,
    input  logic [LW-1:0] len,
    input  logic          retrig,
    output logic          out_bit
);
    logic [LW-1:0] cnt;
    logic          trig;
    logic          running;

`ifdef PULSE_EXTENDER_EDGE_EN
    logic in_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) in_q <= 1'b0;
        else         in_q <= in_bit;
    end

    assign trig = in_bit & ~in_q;
`else
    assign trig = in_bit;
`endif

    assign running = (cnt != '0);

    // len is only looked at on a load, so changing it mid-stretch leaves the
    // running count alone. Non-retriggerable channels ignore triggers while
    // running; a held level therefore reloads only once the count hits zero.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)                      cnt <= '0;
        else if (trig && (!running || retrig)) cnt <= len;
        else if (running)                 cnt <= cnt - 1'b1;
    end

    assign out_bit = trig | running;
endmodule

module pulse_extender #(
    parameter int N  = 4,
    parameter int LW = 4
) (
    input  logic clk,
    input  logic nreset,
    pulse_extender_if.slave bus
);
    logic [N-1:0] out_w;

    for (genvar i = 0; i < N; i++) begin : g_lane
        pulse_extender_lane #(.LW(LW)) u_lane (
            .clk    (clk),
            .nreset (nreset),
            .in_bit (bus.in[i]),
            .len    (bus.len),
            .retrig (bus.retrig),
            .out_bit(out_w[i])
        );
    end

    assign bus.out  = out_w;
    assign bus.busy = |out_w;
endmodule

// File: tb/tb_pulse_extender.sv
// tb_pulse_extender -- directed and randomized checks of pulse_extender.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_pulse_extender;
    localparam int N  = 4;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    pulse_extender_if #(.N(N), .LW(LW)) bus ();

    pulse_extender #(.N(N), .LW(LW)) dut (
        .clk   (clk),
        .nreset(nreset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: each channel remembers the last cycle at which its
    // stretch window ends; a channel is "running" while now <= that cycle.
    int           m_end [N];
    logic [N-1:0] m_prev;
    int           cyc = 0;

    task automatic model_clear();
        for (int k = 0; k < N; k++) m_end[k] = -1;
        m_prev = '0;
    endtask

    task automatic apply_reset();
        bus.in = '0;
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        logic [N-1:0] pat;
        bus.in = '0; bus.len = 4'd7; bus.retrig = 1'b0;
        nreset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.out !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle out=%b busy=%b want out=0000 busy=0", bus.out, bus.busy);
        end
        // in reset, out follows the trigger only
        pat = 4'b0101;
        bus.in = pat; #1;
        checks++;
        if (bus.out !== pat || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_passthru out=%b busy=%b want out=%b busy=1", bus.out, bus.busy, pat);
        end
        @(negedge clk);
        bus.in = '0; #1;
        checks++;
        if (bus.out !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_noload out=%b busy=%b want out=0000 busy=0", bus.out, bus.busy);
        end
        @(negedge clk);
        nreset = 1'b1;
    endtask

`ifndef PULSE_EXTENDER_EDGE_EN
    task automatic test_single_pulse();
        logic [N-1:0] exp;
        bus.len = 4'd3; bus.retrig = 1'b0;
        apply_reset();
        for (int t = 0; t < 20; t++) begin
            bus.in = (t == 10) ? 4'b0001 : 4'b0000;
            #1;
            exp = (t >= 10 && t <= 13) ? 4'b0001 : 4'b0000;
            checks++;
            if (bus.out !== exp || bus.busy !== (|exp)) begin
                errors++;
                $display("FAIL single_pulse t=%0d out=%b busy=%b want out=%b busy=%b",
                         t, bus.out, bus.busy, exp, |exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_retrig();
        logic [N-1:0] exp;
        int last;
        for (int r = 1; r >= 0; r--) begin
            bus.len = 4'd3; bus.retrig = r[0];
            apply_reset();
            last = (r == 1) ? 15 : 13;
            for (int t = 0; t < 20; t++) begin
                bus.in = (t == 10 || t == 12) ? 4'b0010 : 4'b0000;
                #1;
                exp = (t >= 10 && t <= last) ? 4'b0010 : 4'b0000;
                checks++;
                if (bus.out !== exp || bus.busy !== (|exp)) begin
                    errors++;
                    $display("FAIL retrig%0d t=%0d out=%b busy=%b want out=%b",
                             r, t, bus.out, bus.busy, exp);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_passthrough();
        bus.len = 4'd0;
        apply_reset();
        for (int t = 0; t < 100; t++) begin
            bus.in = N'($urandom);
            bus.retrig = 1'($urandom);
            #1;
            checks++;
            if (bus.out !== bus.in || bus.busy !== (|bus.in)) begin
                errors++;
                $display("FAIL passthrough t=%0d out=%b want %b", t, bus.out, bus.in);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_len_change();
        logic [N-1:0] exp;
        bus.len = 4'd15; bus.retrig = 1'b0;
        apply_reset();
        for (int t = 0; t < 40; t++) begin
            if (t >= 6) bus.len = 4'd2;
            bus.in = (t == 5 || t == 30) ? 4'b0001 : 4'b0000;
            #1;
            exp = ((t >= 5 && t <= 20) || (t >= 30 && t <= 32)) ? 4'b0001 : 4'b0000;
            checks++;
            if (bus.out !== exp) begin
                errors++;
                $display("FAIL len_change t=%0d out=%b want %b", t, bus.out, exp);
            end
            @(negedge clk);
        end
    endtask
`else
    task automatic test_edge();
        logic [N-1:0] exp;
        int rise [N];
        rise[0] = 30; rise[1] = 32; rise[2] = 35; rise[3] = 36;
        bus.len = 4'd2; bus.retrig = 1'b0;
        apply_reset();
        for (int t = 0; t < 50; t++) begin
            bus.in = '0;
            if (t >= 10 && t <= 19) bus.in[2] = 1'b1;
            for (int k = 0; k < N; k++)
                if (t >= rise[k] && t < rise[k] + 6) bus.in[k] = 1'b1;
            #1;
            exp = '0;
            if (t >= 10 && t <= 12) exp[2] = 1'b1;
            for (int k = 0; k < N; k++)
                if (t >= rise[k] && t <= rise[k] + 2) exp[k] = 1'b1;
            checks++;
            if (bus.out !== exp || bus.busy !== (|exp)) begin
                errors++;
                $display("FAIL edge t=%0d out=%b busy=%b want out=%b", t, bus.out, bus.busy, exp);
            end
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_async_reset();
        bus.len = 4'd5; bus.retrig = 1'b0;
        apply_reset();
        for (int t = 0; t < 13; t++) begin
            bus.in = (t == 10) ? 4'b0001 : 4'b0000;
            #1;
            if (t >= 10) begin
                checks++;
                if (bus.out !== 4'b0001) begin
                    errors++;
                    $display("FAIL areset_pre t=%0d out=%b want 0001", t, bus.out);
                end
            end
            if (t < 12) @(negedge clk);
        end
        // t=12, mid-cycle: drop reset between edges
        #1 nreset = 1'b0;
        #1;
        checks++;
        if (bus.out !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_drop out=%b busy=%b want 0000/0", bus.out, bus.busy);
        end
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        for (int t = 0; t < 10; t++) begin
            #1;
            checks++;
            if (bus.out !== 4'b0000 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL areset_after t=%0d out=%b want 0000", t, bus.out);
            end
            @(negedge clk);
        end
    endtask

    // Random in/len/retrig against the window model, including back-to-back
    // triggers on the same channel.
    task automatic test_random();
        logic [N-1:0] trig, exp;
        apply_reset();
        for (int t = 0; t < 600; t++) begin
            for (int k = 0; k < N; k++) bus.in[k] = ($urandom_range(0, 3) == 0);
            bus.len    = LW'($urandom_range(0, 15));
            bus.retrig = (t < 300) ? 1'($urandom) : 1'(t[6]);
`ifdef PULSE_EXTENDER_EDGE_EN
            trig = bus.in & ~m_prev;
`else
            trig = bus.in;
`endif
            #1;
            for (int k = 0; k < N; k++) exp[k] = trig[k] || (cyc <= m_end[k]);
            checks++;
            if (bus.out !== exp || bus.busy !== (|exp)) begin
                errors++;
                $display("FAIL random t=%0d out=%b busy=%b want out=%b busy=%b",
                         t, bus.out, bus.busy, exp, |exp);
            end
            for (int k = 0; k < N; k++)
                if (trig[k] && (cyc > m_end[k] || bus.retrig)) m_end[k] = cyc + int'(bus.len);
            m_prev = bus.in;
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        bus.in = '0; bus.len = '0; bus.retrig = 1'b0;
        model_clear();
        test_reset();
`ifndef PULSE_EXTENDER_EDGE_EN
        test_single_pulse();
        test_retrig();
        test_passthrough();
        test_len_change();
`else
        test_edge();
`endif
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
